divider: RTL and testbench
==========================

# divider

Multi-cycle 32-bit integer divider for the CPU execute stage, serving the RISC-V M-extension DIV/DIVU/REM/REMU operations. It accepts a dividend, a divisor and a signedness flag, and produces quotient and remainder after a fixed latency using radix-2 restoring (shift-subtract) iteration. A start/busy/done handshake connects it to the pipeline stall logic.

## Interface
- No parameters; operand width is fixed at 32.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled on a rising edge while busy=0.
- a  input  32  divisor.
- b  input  32  dividend.
- sign  input  1  0 = unsigned (DIVU/REMU), 1 = two's-complement signed (DIV/REM).
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when quotient/remainder become valid.
- quotient  output  32  b / a.
- remainder  output  32  b % a.

## Operation
- Operand roles are fixed: b is the dividend and a is the divisor. Integration must not swap them.
- Capture: when start=1 and busy=0 at an edge, the block latches a, b and sign. The inputs may change afterwards.
- Signed mode: the block divides the magnitudes |b| and |a| as unsigned values. The quotient is negated when sign(b) differs from sign(a). The remainder takes the sign of b (truncation toward zero).
- Iteration: a 64-bit {remainder, quotient} shift register is preloaded with {32'b0, |b|}. Each cycle it shifts left 1, subtracts |a| from the upper half, and keeps the result if it is non-negative (setting quotient LSB=1); otherwise it restores the upper half (LSB=0). This runs for exactly 32 iterations.
- Divide by zero (a=0), in both modes: quotient=32'hFFFF_FFFF and remainder=b. The block does not raise an exception.
- Signed overflow (b=32'h8000_0000, a=32'hFFFF_FFFF, sign=1): quotient=32'h8000_0000 and remainder=0.
- Special cases use the same latency as normal operation; the latency is fixed.
- Results: quotient and remainder are registered. They hold their value from done until the next done, and do not change while busy.
- start while busy=1 is ignored; the block does not queue requests.
- States: IDLE, RUN (iteration counter 0..31), FIX (sign correction and special-case select). Transitions:
  - IDLE→RUN on accepted start.
  - RUN→FIX after iteration 31.
  - FIX→IDLE unconditionally.

## Timing
- Edge E0: start accepted, operands latched, busy=1 visible after E0.
- Edges E1..E32: the 32 iterations.
- Edge E33: outputs updated, done=1 and busy=0 for the cycle following E33.
- Latency from accepting edge to results valid is 33 clocks.
- Throughput: a new start may be accepted on the same edge on which done is high (E34), i.e. back-to-back every 34 clocks.
- done stays high for exactly one cycle.
- Reset: at any rst edge, including mid-operation, the block goes to IDLE and aborts any division in progress. Reset values: busy=0, done=0, quotient=0, remainder=0.
- rst has priority over start on the same edge.

## Test plan
- Unsigned sweep: for all dividends b=1..7 and divisors a=1..b-1, e.g. b=7,a=2 → quotient=3, remainder=1; b=6,a=3 → 2, 0. done must assert exactly 33 clocks after start.
- Signed: b=-7 (FFFFFFF9), a=2, sign=1 → quotient=FFFFFFFD (-3), remainder=FFFFFFFF (-1). The same operands with sign=0 → quotient=7FFFFFFC, remainder=1.
- Divide by zero: b=12345678, a=0, sign=0 and then sign=1 → quotient=FFFFFFFF, remainder=12345678.
- Overflow: b=80000000, a=FFFFFFFF, sign=1 → quotient=80000000, remainder=0, with latency unchanged.
- Handshake:
  - A start pulsed mid-operation is ignored; the results match the first operands.
  - Operands changed after acceptance do not affect the result.
  - Back-to-back start on the done cycle is accepted.
- Reset mid-run: assert rst at iteration 10 → next cycle busy=0, done=0, outputs=0. No done pulse appears later.

Source files
------------

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Multi-cycle 32-bit integer divider for the execute stage (DIV/DIVU/REM/REMU).
// Radix-2 restoring division: one quotient bit per clock, fixed 33-clock
// latency from the accepting edge to valid results, for every operand pair.
//
// Ports
//   clk        in   1   clock, all state changes on the rising edge
//   rst        in   1   synchronous active-high reset, aborts any division
//   start      in   1   request, accepted on an edge while busy=0
//   a          in  32   divisor
//   b          in  32   dividend
//   sign       in   1   0 = unsigned, 1 = two's-complement signed
//   busy       out  1   high while a division is in progress
//   done       out  1   one-cycle pulse when quotient/remainder update
//   quotient   out 32   b / a
//   remainder  out 32   b % a
// -----------------------------------------------------------------------------
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Magnitude of a value; only negative values in signed mode are flipped.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic s);
        logic [31:0] r;
        if (s && v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional two's-complement negation.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        logic [31:0] r;
        if (n) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]  state_q,     state_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic [63:0] rq_q,        rq_d;       // {partial remainder, quotient}
    logic [31:0] div_q,       div_d;      // divisor magnitude
    logic [31:0] b_q,         b_d;        // original dividend, for divide by zero
    logic        qneg_q,      qneg_d;
    logic        rneg_q,      rneg_d;
    logic        dz_q,        dz_d;
    logic        ovf_q,       ovf_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic [31:0] quotient_q,  quotient_d;
    logic [31:0] remainder_q, remainder_d;

    // One restoring step. The shifted partial remainder can reach 33 bits, so
    // the compare uses the bit shifted out of the top; when it is set the
    // subtraction always succeeds and its result fits back into 32 bits.
    logic [32:0] tmp_s;
    logic        ge_s;
    logic [31:0] sub_s;
    logic [63:0] step_s;

    // Shift-subtract datapath for a single iteration.
    always_comb begin
        tmp_s = rq_q[63:31];
        ge_s  = (tmp_s >= {1'b0, div_q});
        sub_s = tmp_s[31:0] - div_q;
        if (ge_s) begin
            step_s = {sub_s, rq_q[30:0], 1'b1};
        end else begin
            step_s = {tmp_s[31:0], rq_q[30:0], 1'b0};
        end
    end

    // Next-state logic: capture, iterate, then sign-fix / special-case select.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rq_d        = rq_q;
        div_d       = div_q;
        b_d         = b_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = 5'd0;
                    rq_d    = {32'd0, magnitude(b, sign)};
                    div_d   = magnitude(a, sign);
                    b_d     = b;
                    qneg_d  = sign && (a[31] ^ b[31]);
                    rneg_d  = sign && b[31];
                    dz_d    = (a == 32'd0);
                    ovf_d   = sign && (b == 32'h8000_0000) && (a == 32'hFFFF_FFFF);
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rq_d = step_s;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    quotient_d  = 32'hFFFF_FFFF;
                    remainder_d = b_q;
                end else if (ovf_q) begin
                    quotient_d  = 32'h8000_0000;
                    remainder_d = 32'd0;
                end else begin
                    quotient_d  = neg_if(rq_q[31:0], qneg_q);
                    remainder_d = neg_if(rq_q[63:32], rneg_q);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            rq_q        <= 64'd0;
            div_q       <= 32'd0;
            b_q         <= 32'd0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rq_q        <= rq_d;
            div_q       <= div_d;
            b_q         <= b_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Self-checking bench for divider: directed cases, reset, handshake and a
// randomized run, all compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] last_q      = 32'd0;
    logic [31:0] last_r      = 32'd0;

    always #5 clk = ~clk;

    divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic with the documented special cases.
    function automatic void ref_div(input logic [31:0] dd, input logic [31:0] dv, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        if (dv == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = dd;
        end else if (s && dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(dd) / $signed(dv);
            r = $signed(dd) % $signed(dv);
        end else begin
            q = dd / dv;
            r = dd % dv;
        end
    endfunction

    // Issue one division (called at #1 after an edge) and check everything
    // up to and including the done cycle. poke pulses a second start mid-run.
    task automatic run_op(input logic [31:0] dv, input logic [31:0] dd, input logic s,
                          input bit poke, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          cyc;
        bit          got;
        ref_div(dd, dv, s, eq, er);
        a     = dv;
        b     = dd;
        sign  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sign  = 1'($urandom_range(1, 0));
        check1({tag, ".busy_after_start"}, busy, 1'b1);
        check1({tag, ".done_after_start"}, done, 1'b0);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 5) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            if (cyc == 16) begin
                check32({tag, ".hold_q"}, quotient, last_q);
                check32({tag, ".hold_r"}, remainder, last_r);
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check1({tag, ".done_seen"}, got, 1'b1);
        check32({tag, ".latency"}, 32'(cyc), 32'd33);
        check32({tag, ".quotient"}, quotient, eq);
        check32({tag, ".remainder"}, remainder, er);
        check1({tag, ".busy_at_done"}, busy, 1'b0);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        int pulses;
        logic [31:0] rdv;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        sign  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset.busy", busy, 1'b0);
        check1("reset.done", done, 1'b0);
        check32("reset.quotient", quotient, 32'd0);
        check32("reset.remainder", remainder, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned sweep; each op starts on the previous done cycle.
        for (int bb = 1; bb <= 7; bb++) begin
            for (int aa = 1; aa < bb; aa++) begin
                run_op(32'(aa), 32'(bb), 1'b0, 1'b0, "sweep");
            end
        end

        run_op(32'd2, 32'hFFFF_FFF9, 1'b1, 1'b0, "signed_m7_2");
        run_op(32'd2, 32'hFFFF_FFF9, 1'b0, 1'b0, "unsigned_m7_2");
        run_op(32'hFFFF_FFFD, 32'd10, 1'b1, 1'b0, "signed_10_m3");
        run_op(32'hFFFF_FFFD, 32'hFFFF_FFF6, 1'b1, 1'b0, "signed_m10_m3");
        run_op(32'd0, 32'h1234_5678, 1'b0, 1'b0, "divzero_u");
        run_op(32'd0, 32'h1234_5678, 1'b1, 1'b0, "divzero_s");
        run_op(32'd0, 32'hF000_0000, 1'b1, 1'b0, "divzero_neg");
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "overflow");
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, "overflow_u");
        run_op(32'd7, 32'd100, 1'b0, 1'b1, "ignored_start");
        run_op(32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, "max_u");

        // Reset during iteration 10: abort, clear outputs, no later done.
        a     = 32'd5;
        b     = 32'd1000;
        sign  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check1("midreset.busy", busy, 1'b0);
        check1("midreset.done", done, 1'b0);
        check32("midreset.quotient", quotient, 32'd0);
        check32("midreset.remainder", remainder, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check32("midreset.no_done", 32'(pulses), 32'd0);
        last_q = 32'd0;
        last_r = 32'd0;

        // Randomized operands, mixing small, zero and full-range divisors.
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 3) begin
                rdv = 32'd0;
            end else if (i % 4 == 0) begin
                rdv = $urandom_range(15, 1);
            end else begin
                rdv = $urandom;
            end
            run_op(rdv, $urandom, 1'($urandom_range(1, 0)), 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
